stack_op_sequencer: RTL and testbench

- Sequences compound JVM operand-stack operations (PUSH, POP, DUP, SWAP, POP2) onto the single-access stack32 push/pop port.
- Sits between the bytecode decode/execute stage and stack32.
- Takes one command at a time over a valid/ready handshake and issues one stack32 access at a time.
- Returns the popped operands with a single-cycle response pulse.

---
 rtl/stack_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: expands JVM operand-stack commands (PUSH, POP, DUP,
// SWAP, POP2) into single push/pop accesses on the stack32 port.
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready/cmd_op/cmd_data
// command handshake; rsp_valid/rsp_a/rsp_b/rsp_error one-cycle response;
// stk_push/stk_trigger/stk_wdata/stk_rdata/stk_done stack32 access port;
// depth tracked occupancy.
// Optional: define STACK_SEQ_BOUNDS_CHECK_EN for a live depth counter and
// over/underflow rejection; otherwise depth reads 0.
module stack_op_sequencer #(
    parameter int DEPTH   = 256,
    parameter int DEPTH_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [31:0]        cmd_data,
    output logic               rsp_valid,
    output logic [31:0]        rsp_a,
    output logic [31:0]        rsp_b,
    output logic               rsp_error,
    output logic               stk_push,
    output logic               stk_trigger,
    output logic [31:0]        stk_wdata,
    input  logic [31:0]        stk_rdata,
    input  logic               stk_done,
    output logic [DEPTH_W-1:0] depth
);

    if (2**DEPTH_W <= DEPTH) begin : g_depth_w_check
        $error("DEPTH_W too narrow for DEPTH");
    end

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_POP2 = 3'd5;

    // Pops always come first: step 0 fills A, step 1 fills B.
    function automatic logic op_push(input logic [2:0] op,
                                     input logic [1:0] step);
        unique case (op)
            OP_PUSH: op_push = 1'b1;
            OP_DUP:  op_push = (step != 2'd0);
            OP_SWAP: op_push = step[1];
            default: op_push = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_last(input logic [2:0] op);
        unique case (op)
            OP_DUP:  op_last = 2'd2;
            OP_SWAP: op_last = 2'd3;
            OP_POP2: op_last = 2'd1;
            default: op_last = 2'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  step_q, step_d;
    logic        err_d;
    logic        step_push;
    logic        bounds_fail;
    logic        nxt_push;
    logic [31:0] nxt_wdata;

    assign cmd_ready = (state_q == IDLE);
    assign step_push = op_push(op_q, step_q);

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

    logic [DEPTH_W-1:0] depth_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else if (state_q == WAIT && stk_done) begin
            depth_q <= step_push ? depth_q + 1'b1 : depth_q - 1'b1;
        end
    end

    always_comb begin
        bounds_fail = 1'b0;
        unique case (op_q)
            OP_PUSH:          bounds_fail = (depth_q == FULL);
            3'd2:             bounds_fail = (depth_q == '0);
            OP_DUP:           bounds_fail = (depth_q == '0) || (depth_q == FULL);
            OP_SWAP, OP_POP2: bounds_fail = (depth_q < DEPTH_W'(2));
            default:          bounds_fail = 1'b0;
        endcase
    end

    assign depth = depth_q;
`else
    assign bounds_fail = 1'b0;
    assign depth       = '0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    step_d  = 2'd0;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (op_q == OP_NOP) begin
                    state_d = RESP;
                end else if (op_q > OP_POP2 || bounds_fail) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (stk_done) begin
                    if (!step_push) begin
                        if (step_q == 2'd0) a_d = stk_rdata;
                        else                b_d = stk_rdata;
                    end
                    if (step_q == op_last(op_q)) begin
                        state_d = RESP;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write data is taken from the next-state A/B so a push can reuse a
    // value popped on the very same edge (DUT of DUP).
    always_comb begin
        nxt_push  = op_push(op_d, step_d);
        nxt_wdata = data_d;
        if (op_d == OP_SWAP && step_d == 2'd3) nxt_wdata = b_d;
        else if (op_d != OP_PUSH)              nxt_wdata = a_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            data_q      <= '0;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            stk_trigger <= 1'b0;
            stk_push    <= 1'b0;
            stk_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_a       <= '0;
            rsp_b       <= '0;
            rsp_error   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            stk_trigger <= (state_d == ISSUE);
            stk_push    <= (state_d == ISSUE) && nxt_push;
            if (state_d == ISSUE && nxt_push) begin
                stk_wdata <= nxt_wdata;
            end
            rsp_valid   <= (state_d == RESP);
            rsp_error   <= (state_d == RESP) && err_d;
            if (state_d == RESP) begin
                rsp_a <= a_d;
                rsp_b <= b_d;
            end
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: drives stack_op_sequencer against a stack32 stand-in
// and checks it against a queue-based operand-stack model.
module tb_stack_op_sequencer;

    localparam int DEPTH   = 256;
    localparam int DEPTH_W = 9;
`ifdef STACK_SEQ_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op = '0;
    logic [31:0]        cmd_data = '0;
    logic               rsp_valid;
    logic [31:0]        rsp_a;
    logic [31:0]        rsp_b;
    logic               rsp_error;
    logic               stk_push;
    logic               stk_trigger;
    logic [31:0]        stk_wdata;
    logic [31:0]        stk_rdata = '0;
    logic               stk_done = 1'b0;
    logic [DEPTH_W-1:0] depth;

    stack_op_sequencer #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_error(rsp_error),
        .stk_push(stk_push), .stk_trigger(stk_trigger),
        .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
        .stk_done(stk_done), .depth(depth)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mstk[$];
    bit          exp_push[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_a, exp_b;
    bit          exp_err;
    bit          pending = 0;
    bit          outstanding = 0;
    int          acc_cyc, last_done, cur_trig;
    logic [3:0]  cur_pat;
    int          n_acc = 0, n_rsp = 0, n_abort = 0;
    logic [31:0] last_a, last_b;
    int          last_err, last_ntrig, last_depth, last_lat;
    logic [3:0]  last_pat;

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
    function automatic bit bounds_reject(input logic [2:0] op);
        int n = mstk.size();
        case (op)
            3'd1:       return n == DEPTH;
            3'd2:       return n < 1;
            3'd3:       return n < 1 || n == DEPTH;
            3'd4, 3'd5: return n < 2;
            default:    return 1'b0;
        endcase
    endfunction
`endif

    task automatic step(input bit p, input logic [31:0] w);
        exp_push.push_back(p);
        exp_wd.push_back(w);
    endtask

    task automatic model_accept(input logic [2:0] op, input logic [31:0] d);
        exp_push.delete();
        exp_wd.delete();
        exp_a   = '0;
        exp_b   = '0;
        exp_err = 1'b0;
        if (op > 3'd5) exp_err = 1'b1;
`ifdef STACK_SEQ_BOUNDS_CHECK_EN
        else if (bounds_reject(op)) exp_err = 1'b1;
`endif
        else begin
            case (op)
                3'd1: begin
                    step(1'b1, d);
                    mstk.push_back(d);
                end
                3'd2: begin
                    exp_a = mstk.pop_back();
                    step(1'b0, '0);
                end
                3'd3: begin
                    exp_a = mstk[$];
                    mstk.push_back(exp_a);
                    step(1'b0, '0);
                    step(1'b1, exp_a);
                    step(1'b1, exp_a);
                end
                3'd4: begin
                    exp_a = mstk.pop_back();
                    exp_b = mstk.pop_back();
                    mstk.push_back(exp_a);
                    mstk.push_back(exp_b);
                    step(1'b0, '0);
                    step(1'b0, '0);
                    step(1'b1, exp_a);
                    step(1'b1, exp_b);
                end
                3'd5: begin
                    exp_a = mstk.pop_back();
                    exp_b = mstk.pop_back();
                    step(1'b0, '0);
                    step(1'b0, '0);
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (pending) n_abort++;
            pending     = 0;
            outstanding = 0;
            mstk.delete();
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!pending));
            if (stk_trigger) begin
                chk("trig_while_idle", 32'(pending), 32'd1);
                chk("trig_outstanding", 32'(outstanding), 32'd0);
                chk("trig_cycle", 32'(cyc),
                    32'(cur_trig == 0 ? acc_cyc + 2 : last_done + 1));
                if (cur_trig < exp_push.size()) begin
                    chk("stk_push", 32'(stk_push), 32'(exp_push[cur_trig]));
                    if (exp_push[cur_trig])
                        chk("stk_wdata", stk_wdata, exp_wd[cur_trig]);
                end else begin
                    chk("extra_trigger", 32'(cur_trig), 32'(exp_push.size()));
                end
                cur_pat = {cur_pat[2:0], stk_push};
                cur_trig++;
                outstanding = 1;
            end
            if (stk_done && outstanding) begin
                outstanding = 0;
                last_done   = cyc;
            end
            if (rsp_valid) begin
                chk("rsp_without_cmd", 32'(pending), 32'd1);
                if (pending) begin
                    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
                    chk("rsp_a", rsp_a, exp_a);
                    chk("rsp_b", rsp_b, exp_b);
                    chk("trigger_count", 32'(cur_trig), 32'(exp_push.size()));
                    chk("rsp_cycle", 32'(cyc),
                        32'(exp_push.size() == 0 ? acc_cyc + 2 : last_done + 1));
                    chk("depth", 32'(depth), BC ? 32'(mstk.size()) : 32'd0);
                    last_a     = rsp_a;
                    last_b     = rsp_b;
                    last_err   = int'(rsp_error);
                    last_ntrig = cur_trig;
                    last_pat   = cur_pat;
                    last_depth = int'(depth);
                    last_lat   = cyc - acc_cyc;
                    n_rsp++;
                    pending = 0;
                end
            end
            if (cmd_valid && cmd_ready) begin
                model_accept(cmd_op, cmd_data);
                pending  = 1;
                acc_cyc  = cyc;
                cur_trig = 0;
                cur_pat  = '0;
                n_acc++;
            end
        end
    end

    // ---------------- stack32 stand-in ----------------
    logic [31:0] mem [0:511];
    int          sp = 0;
    bit          slow = 0;

    initial begin
        logic [31:0] rd;
        int          d;
        forever begin
            @(negedge clk);
            if (rst) sp = 0;
            else if (stk_trigger) begin
                rd = $urandom;
                if (stk_push) begin
                    mem[sp[8:0]] = stk_wdata;
                    sp++;
                end else if (sp > 0) begin
                    sp--;
                    rd = mem[sp[8:0]];
                end
                d = slow ? 4 : int'($urandom_range(0, 3));
                @(posedge clk); #1;
                repeat (d) begin
                    @(posedge clk); #1;
                end
                stk_done  = 1'b1;
                stk_rdata = rd;
                @(posedge clk); #1;
                stk_done  = 1'b0;
                stk_rdata = $urandom;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input logic [31:0] d,
                        input bit hold);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (n_rsp + n_abort == n_acc && cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("rsp_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] d);
        send(op, d, 1'b0);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        int         d1, d2, base, sz;
        bit         ok;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_trigger", 32'(stk_trigger), 32'd0);
        chk("reset_push", 32'(stk_push), 32'd0);
        chk("reset_wdata", stk_wdata, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_a", rsp_a, 32'd0);
        chk("reset_rsp_b", rsp_b, 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);
        chk("reset_depth", 32'(depth), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        run(3'd1, 32'hCAFEBABE);
        run(3'd2, 32'h0);
        chk("pop_a_lit", last_a, 32'hCAFEBABE);
        chk("pop_b_lit", last_b, 32'h0);
        chk("pop_err_lit", 32'(last_err), 32'd0);
        chk("pop_depth_lit", 32'(last_depth), 32'd0);

        run(3'd1, 32'hDEADBEEF);
        run(3'd1, 32'hB105F00D);
        run(3'd4, 32'h0);
        chk("swap_ntrig_lit", 32'(last_ntrig), 32'd4);
        chk("swap_pattern_lit", 32'(last_pat), 32'h3);
        run(3'd5, 32'h0);
        chk("pop2_a_lit", last_a, 32'hDEADBEEF);
        chk("pop2_b_lit", last_b, 32'hB105F00D);

        run(3'd1, 32'h12345678);
        d1 = last_depth;
        run(3'd3, 32'h0);
        d2 = last_depth;
        run(3'd5, 32'h0);
        chk("dup_a_lit", last_a, 32'h12345678);
        chk("dup_b_lit", last_b, 32'h12345678);
        chk("dup_depth1_lit", 32'(d1), BC ? 32'd1 : 32'd0);
        chk("dup_depth2_lit", 32'(d2), BC ? 32'd2 : 32'd0);
        chk("dup_depth3_lit", 32'(last_depth), 32'd0);

        run(3'd7, 32'h0);
        chk("illegal_err_lit", 32'(last_err), 32'd1);
        chk("illegal_ntrig_lit", 32'(last_ntrig), 32'd0);
        chk("illegal_latency_lit", 32'(last_lat), 32'd2);
        run(3'd0, 32'h0);
        chk("nop_err_lit", 32'(last_err), 32'd0);
        chk("nop_ntrig_lit", 32'(last_ntrig), 32'd0);

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
        run(3'd2, 32'h0);
        chk("empty_pop_err_lit", 32'(last_err), 32'd1);
        chk("empty_pop_ntrig_lit", 32'(last_ntrig), 32'd0);
        chk("empty_pop_depth_lit", 32'(last_depth), 32'd0);
        run(3'd4, 32'h0);
        chk("empty_swap_err_lit", 32'(last_err), 32'd1);
        chk("empty_swap_ntrig_lit", 32'(last_ntrig), 32'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            sz = mstk.size();
            if (!BC) begin
                if ((op == 3'd2 || op == 3'd3) && sz < 1) op = 3'd1;
                if ((op == 3'd4 || op == 3'd5) && sz < 2) op = 3'd1;
            end
            if (op == 3'd1 && sz >= 32) op = 3'd5;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run(op, $urandom);
        end

        base = n_acc;
        for (int i = 0; i < 5; i++) send(3'd1, 32'hA000_0000 + i, 1'b1);
        cmd_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", 32'(n_acc - base), 32'd5);
        chk("b2b_responses", 32'(n_rsp + n_abort), 32'(n_acc));
        while (mstk.size() > 0) run(3'd2, 32'h0);

        run(3'd1, 32'h11);
        run(3'd1, 32'h22);
        slow = 1;
        base = n_rsp;
        send(3'd4, 32'h0, 1'b0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (cur_trig >= 2) begin
                ok = 1;
                break;
            end
        end
        chk("swap_second_pop_seen", 32'(ok), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_trigger", 32'(stk_trigger), 32'd0);
        chk("abort_push", 32'(stk_push), 32'd0);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (8) @(posedge clk);
        slow = 0;
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_abort", 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(n_rsp), 32'(base));
        chk("abort_counted", 32'(n_abort), 32'd1);

        run(3'd1, 32'h5A5A_0001);
        run(3'd3, 32'h0);
        run(3'd5, 32'h0);
        chk("post_reset_a_lit", last_a, 32'h5A5A_0001);

        chk("acc_rsp_balance", 32'(n_rsp + n_abort), 32'(n_acc));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
